// File: rtl/mips_dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_dmem_responder_pkg
//  Purpose  : Shared types and MMIO offsets for the data-memory responder.
//  Revision : 1.0
// ============================================================================
package mips_dmem_responder_pkg;

    localparam int DATA_MEM_WIDTH = 32;

    localparam logic [7:0] MMIO_GPIO    = 8'h00;
    localparam logic [7:0] MMIO_CYCLE   = 8'h04;
    localparam logic [7:0] MMIO_TCMP    = 8'h08;
    localparam logic [7:0] MMIO_TCTRL   = 8'h0C;
    localparam logic [7:0] MMIO_TCNT    = 8'h10;
    localparam logic [7:0] MMIO_ERR     = 8'h14;
    localparam logic [7:0] MMIO_ERRADDR = 8'h18;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_MMIO = 2'd1,
        REG_HOLE = 2'd2
    } region_e;

    // Packed so that the struct reads back directly as TMR_CTRL[2:0].
    typedef struct packed {
        logic auto_rl;
        logic pend;
        logic en;
    } tmr_ctrl_t;

    function automatic region_e decode_region(
        input logic [DATA_MEM_WIDTH-1:0] addr,
        input logic [DATA_MEM_WIDTH-1:0] ram_bytes,
        input logic [DATA_MEM_WIDTH-1:0] mmio_base
    );
        if (addr < ram_bytes)
            return REG_RAM;
        else if (addr[31:8] == mmio_base[31:8])
            return REG_MMIO;
        else
            return REG_HOLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : mips_dmem_responder_if
//  Purpose  : Core data-memory port bundle (store strobe, address, data).
//  Revision : 1.0
// ============================================================================
interface mips_dmem_responder_if;
    import mips_dmem_responder_pkg::*;

    logic                      memwrite;
    logic [DATA_MEM_WIDTH-1:0] memaddr;
    logic [DATA_MEM_WIDTH-1:0] writedata;
    logic [DATA_MEM_WIDTH-1:0] readdata;

    modport master (
        output memwrite,
        output memaddr,
        output writedata,
        input  readdata
    );

    modport slave (
        input  memwrite,
        input  memaddr,
        input  writedata,
        output readdata
    );

endinterface
`default_nettype wire

// File: rtl/mips_dmem_responder_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mips_dmem_timer
//  Purpose  : Compare timer (TMR_CMP / TMR_CTRL / TMR_CNT) with sticky PEND.
//  Revision : 1.0
// ============================================================================
module mips_dmem_timer
    import mips_dmem_responder_pkg::*;
(
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      i_wr_cmp,
    input  wire logic                      i_wr_ctrl,
    input  wire logic                      i_wr_cnt,
    input  wire logic [DATA_MEM_WIDTH-1:0] i_wdata,
    output logic      [DATA_MEM_WIDTH-1:0] o_cmp,
    output tmr_ctrl_t                      o_ctrl,
    output logic      [DATA_MEM_WIDTH-1:0] o_cnt
);

    logic [DATA_MEM_WIDTH-1:0] r_cmp_q,  w_cmp_d;
    logic [DATA_MEM_WIDTH-1:0] r_cnt_q,  w_cnt_d;
    tmr_ctrl_t                 r_ctrl_q, w_ctrl_d;
    logic                      w_match;

    always_comb begin
        w_match  = r_ctrl_q.en && (r_cnt_q == r_cmp_q);
        w_cmp_d  = i_wr_cmp ? i_wdata : r_cmp_q;
        w_ctrl_d = r_ctrl_q;
        w_cnt_d  = r_cnt_q;

        if (w_match) begin
            w_ctrl_d.pend = 1'b1;
            if (r_ctrl_q.auto_rl)
                w_cnt_d = '0;
            else
                w_ctrl_d.en = 1'b0;
        end else if (r_ctrl_q.en) begin
            w_cnt_d = r_cnt_q + 32'd1;
        end

        // Software writes land last so they override the timer's own update,
        // except that a match-set of PEND beats a same-cycle W1C.
        if (i_wr_ctrl) begin
            w_ctrl_d.en      = i_wdata[0];
            w_ctrl_d.auto_rl = i_wdata[2];
            if (i_wdata[1] && !w_match)
                w_ctrl_d.pend = 1'b0;
        end
        if (i_wr_cnt)
            w_cnt_d = i_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_q  <= '0;
            r_cnt_q  <= '0;
            r_ctrl_q <= '0;
        end else begin
            r_cmp_q  <= w_cmp_d;
            r_cnt_q  <= w_cnt_d;
            r_ctrl_q <= w_ctrl_d;
        end
    end

    assign o_cmp  = r_cmp_q;
    assign o_ctrl = r_ctrl_q;
    assign o_cnt  = r_cnt_q;

endmodule
`default_nettype wire

// File: rtl/mips_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mips_dmem_responder
//  Purpose  : Data-memory responder: word RAM, MMIO bank (GPIO, cycle counter,
//             compare timer) and unmapped holes. Optional DMEM_ERR_TRAP_EN
//             adds a sticky hole-access error flag and fault address latch.
//  Revision : 1.0
// ============================================================================
module mips_dmem_responder
    import mips_dmem_responder_pkg::*;
#(
    parameter int                        DEPTH     = 64,
    parameter logic [DATA_MEM_WIDTH-1:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input  wire logic               clk,
    input  wire logic               rst,
    mips_dmem_responder_if.slave    bus,
    output logic [31:0]             gpio_out,
    output logic                    timer_irq
);

    localparam int                        c_aw        = $clog2(DEPTH);
    localparam logic [DATA_MEM_WIDTH-1:0] c_ram_bytes = 32'(DEPTH * 4);

    logic [DATA_MEM_WIDTH-1:0] r_mem_q [DEPTH];

    region_e                   w_region;
    logic [7:0]                w_off;
    logic                      w_ram_we;
    logic                      w_mmio_we;
    logic [31:0]               r_gpio_q,  w_gpio_d;
    logic [31:0]               r_cycle_q, w_cycle_d;
    logic [DATA_MEM_WIDTH-1:0] w_tmr_cmp;
    logic [DATA_MEM_WIDTH-1:0] w_tmr_cnt;
    tmr_ctrl_t                 w_tmr_ctrl;
    logic [31:0]               w_err_rd;
    logic [31:0]               w_erraddr_rd;

    assign w_region  = decode_region(bus.memaddr, c_ram_bytes, MMIO_BASE);
    assign w_off     = {bus.memaddr[7:2], 2'b00};
    // Reset takes priority over a same-cycle store.
    assign w_ram_we  = bus.memwrite && !rst && (w_region == REG_RAM);
    assign w_mmio_we = bus.memwrite && !rst && (w_region == REG_MMIO);

    always_ff @(posedge clk) begin
        if (w_ram_we)
            r_mem_q[bus.memaddr[c_aw+1:2]] <= bus.writedata;
    end

    always_comb begin
        w_gpio_d  = r_gpio_q;
        w_cycle_d = r_cycle_q + 32'd1;
        if (w_mmio_we && (w_off == MMIO_GPIO))
            w_gpio_d = bus.writedata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpio_q  <= '0;
            r_cycle_q <= '0;
        end else begin
            r_gpio_q  <= w_gpio_d;
            r_cycle_q <= w_cycle_d;
        end
    end

    assign gpio_out = r_gpio_q;

    mips_dmem_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_wr_cmp  (w_mmio_we && (w_off == MMIO_TCMP)),
        .i_wr_ctrl (w_mmio_we && (w_off == MMIO_TCTRL)),
        .i_wr_cnt  (w_mmio_we && (w_off == MMIO_TCNT)),
        .i_wdata   (bus.writedata),
        .o_cmp     (w_tmr_cmp),
        .o_ctrl    (w_tmr_ctrl),
        .o_cnt     (w_tmr_cnt)
    );

`ifdef DMEM_ERR_TRAP_EN
    logic        r_err_q,     w_err_d;
    logic [31:0] r_erraddr_q, w_erraddr_d;

    // Any cycle out of reset with a hole address counts as an access.
    always_comb begin
        w_err_d     = r_err_q;
        w_erraddr_d = r_erraddr_q;
        if (w_mmio_we && (w_off == MMIO_ERR) && bus.writedata[0])
            w_err_d = 1'b0;
        if ((w_region == REG_HOLE) && !r_err_q) begin
            w_err_d     = 1'b1;
            w_erraddr_d = bus.memaddr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_q     <= 1'b0;
            r_erraddr_q <= '0;
        end else begin
            r_err_q     <= w_err_d;
            r_erraddr_q <= w_erraddr_d;
        end
    end

    assign w_err_rd     = {31'b0, r_err_q};
    assign w_erraddr_rd = r_erraddr_q;
    assign timer_irq    = w_tmr_ctrl.pend | r_err_q;
`else
    assign w_err_rd     = '0;
    assign w_erraddr_rd = '0;
    assign timer_irq    = w_tmr_ctrl.pend;
`endif

    always_comb begin
        bus.readdata = '0;
        case (w_region)
            REG_RAM:  bus.readdata = r_mem_q[bus.memaddr[c_aw+1:2]];
            REG_MMIO: begin
                case (w_off)
                    MMIO_GPIO:    bus.readdata = r_gpio_q;
                    MMIO_CYCLE:   bus.readdata = r_cycle_q;
                    MMIO_TCMP:    bus.readdata = w_tmr_cmp;
                    MMIO_TCTRL:   bus.readdata = {29'b0, w_tmr_ctrl};
                    MMIO_TCNT:    bus.readdata = w_tmr_cnt;
                    MMIO_ERR:     bus.readdata = w_err_rd;
                    MMIO_ERRADDR: bus.readdata = w_erraddr_rd;
                    default:      bus.readdata = '0;
                endcase
            end
            default:  bus.readdata = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_dmem_responder
//  Purpose  : Self-checking bench: directed vector table, hand-written corner
//             sequences (reset, DMEM_ERR_TRAP_EN trap) and a random run
//             checked against a behavioural model.
//  Revision : 1.0
// ============================================================================
module tb_mips_dmem_responder;
    import mips_dmem_responder_pkg::*;

    localparam int          DEPTH = 64;
    localparam logic [31:0] B     = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] gpio_out;
    logic        timer_irq;
    int          checks   = 0;
    int          failures = 0;

    mips_dmem_responder_if ifc ();

    mips_dmem_responder #(.DEPTH(DEPTH), .MMIO_BASE(B)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifc),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] m_ram [int];
    logic [31:0] m_gpio, m_cycle, m_cmp, m_cnt, m_erraddr;
    logic        m_en, m_pend, m_auto, m_err;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endfunction

    function automatic int region(input logic [31:0] a);
        if (a < DEPTH * 4) return 0;
        if (a[31:8] == B[31:8]) return 1;
        return 2;
    endfunction

    function automatic bit model_known(input logic [31:0] a);
        if (region(a) == 0) return m_ram.exists(int'(a >> 2));
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int off;
        off = int'(a[7:0]) & 32'hFC;
        if (region(a) == 0) return m_ram[int'(a >> 2)];
        if (region(a) == 2) return 32'h0;
        case (off)
            'h00: return m_gpio;
            'h04: return m_cycle;
            'h08: return m_cmp;
            'h0C: return {29'b0, m_auto, m_pend, m_en};
            'h10: return m_cnt;
`ifdef DMEM_ERR_TRAP_EN
            'h14: return {31'b0, m_err};
            'h18: return m_erraddr;
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_irq();
        return m_pend | m_err;
    endfunction

    function automatic void model_reset();
        m_gpio = 0; m_cycle = 0; m_cmp = 0; m_cnt = 0; m_erraddr = 0;
        m_en = 0; m_pend = 0; m_auto = 0; m_err = 0;
    endfunction

    function automatic void model_update(input logic we, input logic [31:0] a, input logic [31:0] d, input logic r);
        bit match;
        int off;
        if (r) begin
            model_reset();
            return;
        end
        off   = int'(a[7:0]) & 32'hFC;
        match = m_en && (m_cnt == m_cmp);
        if (match) begin
            m_pend = 1;
            if (m_auto) m_cnt = 0;
            else        m_en  = 0;
        end else if (m_en) begin
            m_cnt = m_cnt + 1;
        end
        if (we && region(a) == 1) begin
            case (off)
                'h00: m_gpio = d;
                'h08: m_cmp  = d;
                'h0C: begin
                    m_en   = d[0];
                    m_auto = d[2];
                    if (d[1] && !match) m_pend = 0;
                end
                'h10: m_cnt = d;
`ifdef DMEM_ERR_TRAP_EN
                'h14: if (d[0]) m_err = 0;
`endif
                default: ;
            endcase
        end
`ifdef DMEM_ERR_TRAP_EN
        if (region(a) == 2 && !m_err) begin
            m_err     = 1;
            m_erraddr = a;
        end
`endif
        if (we && region(a) == 0) m_ram[int'(a >> 2)] = d;
        m_cycle = m_cycle + 1;
    endfunction

    // One bus cycle: drive at negedge, sample mid-cycle, advance model at posedge.
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic r, input string tag, output logic [31:0] rd);
        @(negedge clk);
        rst           = r;
        ifc.memwrite  = we;
        ifc.memaddr   = a;
        ifc.writedata = d;
        #1;
        rd = ifc.readdata;
        if (model_known(a)) chk({tag, "_rdata"}, rd, model_read(a));
        chk({tag, "_gpio"}, gpio_out, m_gpio);
        chk({tag, "_irq"}, {31'b0, timer_irq}, {31'b0, model_irq()});
        @(posedge clk);
        model_update(we, a, d, r);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void v(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic c, input logic [31:0] e);
        vec_t t;
        t.we = we; t.a = a; t.d = d; t.chk = c; t.exp = e;
        tbl.push_back(t);
    endfunction

    initial begin
        logic [31:0] rd, rd2, a, d;
        logic        we;
        int          sel;

        model_reset();
        ifc.memwrite = 0; ifc.memaddr = 0; ifc.writedata = 0;

        step(0, B + 32'h04, 0, 1, "rst0", rd);
        step(0, B + 32'h04, 0, 1, "rst1", rd);
        step(0, B + 32'h04, 0, 0, "reset_cycle", rd);
        chk("reset_cycle_zero", rd, 32'h0);
        step(0, B + 32'h0C, 0, 0, "reset_ctrl", rd);
        chk("reset_ctrl_zero", rd, 32'h0);

        // RAM read-during-write, hole, GPIO
        v(1, 32'h10, 32'h0, 0, 0);
        v(1, 32'h10, 32'hDEAD_BEEF, 1, 32'h0);
        v(0, 32'h10, 0, 1, 32'hDEAD_BEEF);
        v(0, 32'h13, 0, 1, 32'hDEAD_BEEF);
        v(1, 32'h100, 32'h1234, 1, 32'h0);
        v(0, 32'h100, 0, 1, 32'h0);
        v(1, B + 32'h14, 32'h1, 0, 0);
        v(1, B + 32'h00, 32'hA5A5_A5A5, 1, 32'h0);
        v(0, B + 32'h00, 0, 1, 32'hA5A5_A5A5);
        v(1, B + 32'h04, 32'hFFFF_FFFF, 0, 0);
        // One-shot: CMP=3, PEND 4 cycles after enable
        v(1, B + 32'h10, 32'h0, 1, 32'h0);
        v(1, B + 32'h08, 32'h3, 1, 32'h0);
        v(1, B + 32'h0C, 32'h1, 1, 32'h0);
        v(0, B + 32'h10, 0, 1, 32'h0);
        v(0, B + 32'h10, 0, 1, 32'h1);
        v(0, B + 32'h10, 0, 1, 32'h2);
        v(0, B + 32'h10, 0, 1, 32'h3);
        v(0, B + 32'h10, 0, 1, 32'h3);
        v(0, B + 32'h0C, 0, 1, 32'h2);
        v(1, B + 32'h0C, 32'h2, 1, 32'h2);
        v(0, B + 32'h0C, 0, 1, 32'h0);
        // Auto-reload: CMP=2, W1C on a match cycle
        v(1, B + 32'h10, 32'h0, 1, 32'h3);
        v(1, B + 32'h08, 32'h2, 1, 32'h3);
        v(1, B + 32'h0C, 32'h5, 1, 32'h0);
        v(0, B + 32'h10, 0, 1, 32'h0);
        v(0, B + 32'h10, 0, 1, 32'h1);
        v(0, B + 32'h10, 0, 1, 32'h2);
        v(0, B + 32'h10, 0, 1, 32'h0);
        v(0, B + 32'h10, 0, 1, 32'h1);
        v(1, B + 32'h0C, 32'h7, 1, 32'h7);
        v(0, B + 32'h10, 0, 1, 32'h0);
        v(0, B + 32'h0C, 0, 1, 32'h7);
        v(1, B + 32'h0C, 32'h2, 0, 0);
        v(1, B + 32'h0C, 32'h2, 0, 0);
        v(0, B + 32'h0C, 0, 1, 32'h0);
        // CMP=0 with AUTO: PEND every cycle, CNT stays 0
        v(1, B + 32'h10, 32'h0, 0, 0);
        v(1, B + 32'h08, 32'h0, 0, 0);
        v(1, B + 32'h0C, 32'h5, 1, 32'h0);
        v(0, B + 32'h10, 0, 1, 32'h0);
        v(0, B + 32'h10, 0, 1, 32'h0);
        v(0, B + 32'h0C, 0, 1, 32'h7);
        v(1, B + 32'h0C, 32'h2, 0, 0);
        v(1, B + 32'h0C, 32'h2, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].we, tbl[i].a, tbl[i].d, 0, $sformatf("vec%0d", i), rd);
            if (tbl[i].chk) chk($sformatf("vec%0d_table", i), rd, tbl[i].exp);
        end

        step(0, B + 32'h04, 0, 0, "cyc_a", rd);
        step(0, B + 32'h04, 0, 0, "cyc_b", rd2);
        chk("cycle_inc", rd2 - rd, 32'h1);

        // Reset mid-sequence with a same-cycle GPIO store
        step(1, 32'h20, 32'hCAFE_F00D, 0, "rs_ram", rd);
        step(1, B, 32'h0000_FFFF, 0, "rs_gpio", rd);
        step(1, B + 32'h10, 0, 0, "rs_cnt", rd);
        step(1, B + 32'h08, 0, 0, "rs_cmp", rd);
        step(1, B + 32'h0C, 32'h1, 0, "rs_ctrl", rd);
        step(0, 32'h0, 0, 0, "rs_idle", rd);
        #1 chk("rs_irq_before", {31'b0, timer_irq}, 32'h1);
        chk("rs_gpio_before", gpio_out, 32'h0000_FFFF);
        step(1, B, 32'h1234, 1, "rs_reset", rd);
        #1 chk("rs_gpio_after", gpio_out, 32'h0);
        chk("rs_irq_after", {31'b0, timer_irq}, 32'h0);
        step(0, B, 0, 0, "rs_gpio_rd", rd);
        chk("rs_store_dropped", rd, 32'h0);
        step(0, 32'h20, 0, 0, "rs_ram_rd", rd);
        chk("rs_ram_kept", rd, 32'hCAFE_F00D);

`ifdef DMEM_ERR_TRAP_EN
        step(0, 32'h0000_4000, 0, 0, "err_load", rd);
        step(0, B + 32'h14, 0, 0, "err_flag", rd);
        chk("err_set", rd, 32'h1);
        step(0, B + 32'h18, 0, 0, "err_addr", rd);
        chk("err_addr_first", rd, 32'h0000_4000);
        step(1, 32'h0000_8000, 32'h5, 0, "err_second", rd);
        step(0, B + 32'h18, 0, 0, "err_addr2", rd);
        chk("err_addr_held", rd, 32'h0000_4000);
        #1 chk("err_irq", {31'b0, timer_irq}, 32'h1);
        step(1, B + 32'h14, 32'h1, 0, "err_w1c", rd);
        step(0, B + 32'h14, 0, 0, "err_clr", rd);
        chk("err_cleared", rd, 32'h0);
        #1 chk("err_irq_clr", {31'b0, timer_irq}, 32'h0);
`endif

        for (int n = 0; n < 600; n++) begin
            sel = int'($urandom_range(0, 9));
            we  = 1'($urandom_range(0, 1));
            d   = $urandom;
            if (sel < 4) begin
                a = {24'b0, 2'($urandom_range(0, 3)) == 2'd0 ? 6'($urandom) : 6'($urandom_range(0, 7)), 2'($urandom)};
            end else if (sel < 9) begin
                a = B + {24'b0, 8'($urandom_range(0, 8) * 4)};
                if (a[7:0] == 8'h0C) d = {29'b0, 3'($urandom)};
                if (a[7:0] == 8'h08 || a[7:0] == 8'h10) d = $urandom_range(0, 6);
            end else begin
                a = 32'h0001_0000 | ($urandom & 32'h00FF_FFFC);
            end
            step(we, a, d, ($urandom_range(0, 49) == 0), $sformatf("rnd%0d", n), rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_dmem_responder.md
Name: mips_dmem_responder

Overview:
Responder end of the core's data-memory port (memwrite/memaddr/writedata/readdata).
- Decodes every core load/store into one of: word RAM, an MMIO register bank (GPIO, free-running cycle counter, compare timer with IRQ), or an unmapped hole.
- Sits beside the core in the top level, replacing a bare RAM.
- Word-addressed only; no byte enables.

Parameters:
DEPTH, 64, number of 32-bit RAM words (power of 2, ≥4).
MMIO_BASE, 32'hFFFF_FF00, byte base of the MMIO bank (256-byte aligned).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
memwrite  in  1  store strobe from core, sampled at posedge clk
memaddr  in  DATA_MEM_WIDTH  byte address from core; bits [1:0] ignored
writedata  in  DATA_MEM_WIDTH  store data
readdata  out  DATA_MEM_WIDTH  load data, combinational from memaddr
gpio_out  out  32  GPIO register value
timer_irq  out  1  level IRQ, equals TIMER_CTRL.pending

Behaviour:
- Reset: one synchronous, active-high reset; rst is sampled at posedge clk.
  - On reset, all MMIO registers, gpio_out and timer_irq go to 0.
  - RAM contents are not reset.
  - Reset has priority over a same-cycle store; that store is dropped.
- Region decode:
  - RAM: memaddr < DEPTH*4.
  - MMIO: memaddr[31:8] == MMIO_BASE[31:8].
  - Everything else is a hole.
- Reads: zero-latency combinational.
  - Read-during-write to the same address returns the pre-write value; new data is visible the next cycle.
- Writes: take effect at the posedge where memwrite=1. Writes to a hole, or to read-only MMIO offsets, are dropped.
- Hole and undefined MMIO offsets read 0.
- MMIO offsets (memaddr[7:0]):
  - 0x00 GPIO: RW. Drives gpio_out.
  - 0x04 CYCLE: RO. +1 every cycle out of reset, wraps 0xFFFF_FFFF→0.
  - 0x08 TMR_CMP: RW.
  - 0x0C TMR_CTRL: bit0 EN (RW), bit1 PEND (read; write 1 clears), bit2 AUTO (RW). Other bits read 0.
  - 0x10 TMR_CNT: RW.
- Timer, per cycle:
  - If EN and TMR_CNT==TMR_CMP: set PEND.
    - If AUTO: TMR_CNT←0.
    - Else: EN←0 and TMR_CNT holds.
  - Else if EN: TMR_CNT+1, wrapping.
- Timer boundary rules:
  - A software write to TMR_CNT in the same cycle overrides the increment/reload; the match is still evaluated on the old value.
  - A PEND set and a W1C in the same cycle: set wins.
  - A write to TMR_CTRL.EN in the same cycle as a one-shot auto-clear: the write wins.
- CMP=0 with AUTO: PEND is set every cycle, TMR_CNT stays 0.

Optional Feature:
Macro DMEM_ERR_TRAP_EN.
- Defined:
  - Any access (load address presented, or memwrite=1) to a hole sets a sticky ERR bit at offset 0x14 bit0 (write 1 clears).
  - The faulting byte address is latched at 0x18. The first fault wins until ERR is cleared.
  - timer_irq becomes PEND | ERR.
- Undefined: offsets 0x14/0x18 read 0; timer_irq = PEND.
- Note: a load is "presented" whenever memaddr decodes to a hole in a cycle with rst=0.

Decomposition:
- mips_pkg additions:
  - MMIO offset localparams (MMIO_GPIO, MMIO_CYCLE, MMIO_TCMP, MMIO_TCTRL, MMIO_TCNT, MMIO_ERR, MMIO_ERRADDR).
  - A typedef enum for the region decode {REG_RAM, REG_MMIO, REG_HOLE}.
  - A packed struct for TMR_CTRL bits.
- One sub-module, mips_dmem_timer: owns TMR_CMP/TMR_CTRL/TMR_CNT, the match logic and PEND; takes decoded write strobes.
- RAM, decode, GPIO and CYCLE stay in the top.

Test Plan:
- Store 0xDEADBEEF to 0x10; load 0x10 in the same cycle → 0 (old value); next cycle → 0xDEADBEEF. Load 0x13 → 0xDEADBEEF.
- Store to DEPTH*4, then load it → 0. Store to MMIO_BASE+0x04 → CYCLE unaffected and still incrementing. Read CYCLE on two consecutive cycles → values differ by 1.
- TMR_CMP=3, TMR_CTRL=0x1 (one-shot):
  - PEND and timer_irq go to 1 exactly 4 cycles after the enabling write.
  - EN reads 0 and TMR_CNT holds at 3.
  - Writing 0x2 to TMR_CTRL clears timer_irq.
- TMR_CMP=2, TMR_CTRL=0x5 (auto-reload) → TMR_CNT sequence 0,1,2,0,1,2; PEND stays 1. A W1C issued in the same cycle as a match leaves PEND=1.
- Assert rst mid-sequence with memwrite=1 to GPIO → gpio_out=0, timer_irq=0, store dropped; RAM word written earlier still reads back.
- With DMEM_ERR_TRAP_EN: load 0x0000_4000 → ERR=1, 0x18 reads 0x0000_4000. A second hole access at 0x8000 leaves 0x18 unchanged. timer_irq=1 until ERR is W1C'd.
